// File: rtl/rv32i_insn_encoder_pkg.sv
// RV32I type definitions shared by the instruction encoder and its packing stage.
// Holds the opcode and funct3 enums, instruction format tags and FIFO entry layout.
package rv32i_insn_encoder_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    f3_beq  = 3'b000,
    f3_bne  = 3'b001,
    f3_blt  = 3'b100,
    f3_bge  = 3'b101,
    f3_bltu = 3'b110,
    f3_bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    f3_lb  = 3'b000,
    f3_lh  = 3'b001,
    f3_lw  = 3'b010,
    f3_lbu = 3'b100,
    f3_lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    f3_sb = 3'b000,
    f3_sh = 3'b001,
    f3_sw = 3'b010
  } store_funct3_t;

  typedef enum logic [2:0] {
    fmt_r,
    fmt_i,
    fmt_s,
    fmt_b,
    fmt_u,
    fmt_j
  } insn_format_t;

  localparam logic [6:0]  FUNCT7_ALT = 7'h20;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  typedef struct packed {
    logic        illegal;
    logic [31:0] insn;
  } fifo_entry_t;

  // True when v is representable as a two's-complement value of the given bit width.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] top;
    top = 32'($signed(v) >>> (bits - 1));
    return (top == '0) || (top == '1);
  endfunction

endpackage

// File: rtl/rv32i_insn_encoder_insn_pack.sv
// Combinational field-to-word packer for RV32I. Illegal field combinations
// produce a zero word together with the illegal flag.
module insn_pack
  import rv32i_insn_encoder_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] insn,
  output logic        illegal
);

  rv32i_opcode  op;
  insn_format_t fmt;
  logic         known;
  logic         is_shift;
  logic         bad_imm;
  logic         bad_funct;
  logic [6:0]   funct7;
  logic [11:0]  imm_i;
  logic [31:0]  raw;

  assign op       = rv32i_opcode'(opcode);
  assign is_shift = (op == op_imm) && ((funct3 == 3'b001) || (funct3 == 3'b101));
  assign funct7   = alt ? FUNCT7_ALT : 7'h00;
  // Shift immediates carry the SRAI selector in bit 10 rather than a sign-extended value.
  assign imm_i    = is_shift ? {1'b0, alt, 5'b0, imm[4:0]} : imm[11:0];

  always_comb begin
    fmt   = fmt_i;
    known = 1'b1;
    case (op)
      op_reg:                           fmt = fmt_r;
      op_imm, op_load, op_jalr, op_csr: fmt = fmt_i;
      op_store:                         fmt = fmt_s;
      op_br:                            fmt = fmt_b;
      op_lui, op_auipc:                 fmt = fmt_u;
      op_jal:                           fmt = fmt_j;
      default:                          known = 1'b0;
    endcase
  end

  always_comb begin
    bad_imm = 1'b0;
    case (fmt)
      fmt_i:   bad_imm = is_shift ? (imm[31:5] != '0) : !fits_signed(imm, 12);
      fmt_s:   bad_imm = !fits_signed(imm, 12);
      fmt_b:   bad_imm = !fits_signed(imm, 13) || imm[0];
      fmt_j:   bad_imm = !fits_signed(imm, 21) || imm[0];
      fmt_u:   bad_imm = (imm[11:0] != '0);
      default: bad_imm = 1'b0;
    endcase
  end

  always_comb begin
    bad_funct = 1'b0;
    case (op)
      op_load:  bad_funct = !(funct3 inside {f3_lb, f3_lh, f3_lw, f3_lbu, f3_lhu});
      op_store: bad_funct = !(funct3 inside {f3_sb, f3_sh, f3_sw});
      op_br:    bad_funct = !(funct3 inside {f3_beq, f3_bne, f3_blt, f3_bge, f3_bltu, f3_bgeu});
      op_jalr:  bad_funct = (funct3 != 3'b000);
      op_reg:   bad_funct = alt && (funct3 != 3'b000) && (funct3 != 3'b101);
      op_imm:   bad_funct = alt && (funct3 != 3'b101);
      default:  bad_funct = 1'b0;
    endcase
  end

  always_comb begin
    raw = '0;
    case (fmt)
      fmt_r:   raw = {funct7, rs2, rs1, funct3, rd, opcode};
      fmt_i:   raw = {imm_i, rs1, funct3, rd, opcode};
      fmt_s:   raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      fmt_b:   raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      fmt_u:   raw = {imm[31:12], rd, opcode};
      fmt_j:   raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: raw = '0;
    endcase
  end

  assign illegal = !known || bad_imm || bad_funct;
  assign insn    = illegal ? 32'h0 : raw;

endmodule

// File: rtl/rv32i_insn_encoder.sv
// RV32I instruction encoder: accepts decoded fields, packs and range-checks them,
// and queues the resulting words in a small FIFO for the fetch-path injector.
module rv32i_insn_encoder
  import rv32i_insn_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic             in_alt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_insn,
  output logic             out_illegal,
  output logic [CNT_W-1:0] encoded_count,
  output logic [7:0]       illegal_count
);

  localparam int PTR_W = $clog2(DEPTH);

  fifo_entry_t      mem [DEPTH];
  fifo_entry_t      new_entry;
  fifo_entry_t      head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;
  logic [31:0]      pack_insn;
  logic             pack_illegal;

  insn_pack u_pack (
    .opcode  (in_opcode),
    .funct3  (in_funct3),
    .alt     (in_alt),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .insn    (pack_insn),
    .illegal (pack_illegal)
  );

  assign new_entry = '{illegal: pack_illegal, insn: pack_insn};

  // in_ready depends on stored occupancy only, never on out_ready.
  assign in_ready  = (count != (PTR_W + 1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head        = mem[rd_ptr];
  assign out_insn    = out_valid ? head.insn : 32'h0;
  assign out_illegal = out_valid && head.illegal;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Accepted-bundle counter wraps; illegal counter sticks at its maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      encoded_count <= '0;
      illegal_count <= '0;
    end else if (push) begin
      encoded_count <= encoded_count + CNT_W'(1);
      if (pack_illegal && (illegal_count != 8'hFF)) begin
        illegal_count <= illegal_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_insn_encoder.sv
// Self-checking bench for rv32i_insn_encoder: directed cases plus randomized
// traffic checked against a queue-based reference model of encoder and FIFO.
module tb_rv32i_insn_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_REG   = 7'h33;
  localparam logic [6:0] OP_CSR   = 7'h73;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [6:0]       in_opcode = '0;
  logic [2:0]       in_funct3 = '0;
  logic             in_alt = 1'b0;
  logic [4:0]       in_rd = '0;
  logic [4:0]       in_rs1 = '0;
  logic [4:0]       in_rs2 = '0;
  logic [31:0]      in_imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_insn;
  logic             out_illegal;
  logic [CNT_W-1:0] encoded_count;
  logic [7:0]       illegal_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0]      exp_q[$];
  logic [CNT_W-1:0] exp_enc = '0;
  int               exp_ill = 0;

  rv32i_insn_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_funct3     (in_funct3),
    .in_alt        (in_alt),
    .in_rd         (in_rd),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_imm        (in_imm),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_insn      (out_insn),
    .out_illegal   (out_illegal),
    .encoded_count (encoded_count),
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fld(input int v, input int mask, input int pos);
    return 32'(v & mask) << pos;
  endfunction

  // Reference encoder: ranges as integer arithmetic, fields placed by shifting.
  function automatic logic [32:0] ref_encode(input logic [6:0] op, input logic [2:0] f3,
                                             input logic a, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [31:0] immv);
    int          s;
    int          f;
    bit          bad;
    logic [31:0] w;
    s   = int'(immv);
    f   = int'(f3);
    bad = 0;
    w   = fld(int'(op), 'h7F, 0) | fld(f, 7, 12);
    case (op)
      OP_REG: begin
        if (a && f != 0 && f != 5) bad = 1;
        w = w | fld(a ? 32 : 0, 'h7F, 25) | fld(int'(rs2), 31, 20) | fld(int'(rs1), 31, 15)
              | fld(int'(rd), 31, 7);
      end
      OP_IMM, OP_LOAD, OP_JALR, OP_CSR: begin
        if (op == OP_IMM && (f == 1 || f == 5)) begin
          if (s < 0 || s > 31) bad = 1;
          w = w | fld(a ? 'h400 : 0, 'hFFF, 20) | fld(s, 31, 20);
        end else begin
          if (s < -2048 || s > 2047) bad = 1;
          w = w | fld(s, 'hFFF, 20);
        end
        if (op == OP_IMM && a && f != 5) bad = 1;
        if (op == OP_LOAD && (f == 3 || f == 6 || f == 7)) bad = 1;
        if (op == OP_JALR && f != 0) bad = 1;
        w = w | fld(int'(rs1), 31, 15) | fld(int'(rd), 31, 7);
      end
      OP_STORE: begin
        if (s < -2048 || s > 2047 || f > 2) bad = 1;
        w = w | fld(s >> 5, 'h7F, 25) | fld(int'(rs2), 31, 20) | fld(int'(rs1), 31, 15)
              | fld(s, 31, 7);
      end
      OP_BR: begin
        if (s < -4096 || s > 4094 || (s & 1) != 0 || f == 2 || f == 3) bad = 1;
        w = w | fld(s >> 12, 1, 31) | fld(s >> 5, 'h3F, 25) | fld(int'(rs2), 31, 20)
              | fld(int'(rs1), 31, 15) | fld(s >> 1, 'hF, 8) | fld(s >> 11, 1, 7);
      end
      OP_LUI, OP_AUIPC: begin
        if ((s & 'hFFF) != 0) bad = 1;
        w = fld(int'(op), 'h7F, 0) | fld(int'(rd), 31, 7) | 32'(s & 32'hFFFF_F000);
      end
      OP_JAL: begin
        if (s < -(1 << 20) || s > (1 << 20) - 2 || (s & 1) != 0) bad = 1;
        w = fld(int'(op), 'h7F, 0) | fld(int'(rd), 31, 7) | fld(s >> 20, 1, 31)
          | fld(s >> 1, 'h3FF, 21) | fld(s >> 11, 1, 20) | fld(s >> 12, 'hFF, 12);
      end
      default: bad = 1;
    endcase
    return bad ? {1'b1, 32'h0} : {1'b0, w};
  endfunction

  // Model runs at the falling edge: compare outputs, then advance over the coming rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_enc = '0;
      exp_ill = 0;
    end
    checkOutput("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
    checkOutput("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    checkOutput("out_insn", 64'(out_insn), exp_q.size() != 0 ? 64'(exp_q[0][31:0]) : 64'h0);
    checkOutput("out_illegal", 64'(out_illegal), exp_q.size() != 0 ? 64'(exp_q[0][32]) : 64'h0);
    checkOutput("encoded_count", 64'(encoded_count), 64'(exp_enc));
    checkOutput("illegal_count", 64'(illegal_count), 64'(exp_ill));
    if (!rst) begin
      logic        do_push;
      logic        do_pop;
      logic [32:0] e;
      do_push = in_valid && (exp_q.size() < DEPTH);
      do_pop  = out_ready && (exp_q.size() != 0);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        e = ref_encode(in_opcode, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm);
        exp_q.push_back(e);
        exp_enc = exp_enc + 1'b1;
        if (e[32] && exp_ill < 255) exp_ill++;
      end
    end
  end

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic a,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm);
    in_opcode = op;
    in_funct3 = f3;
    in_alt    = a;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    in_valid  = 1'b1;
    @(posedge clk);
    #2;
    in_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [31:0] pick_imm();
    case ($urandom_range(0, 15))
      0:       return 32'd0;
      1:       return 32'd31;
      2:       return 32'd32;
      3:       return 32'd2047;
      4:       return 32'd2048;
      5:       return -32'sd2048;
      6:       return -32'sd2049;
      7:       return 32'd4094;
      8:       return -32'sd4096;
      9:       return 32'd3;
      10:      return 32'h000F_FFFE;
      11:      return 32'h0010_0000;
      12:      return 32'hFFF0_0000;
      13:      return {$urandom_range(0, 32'hFFFFF), 12'h000};
      14:      return $urandom;
      default: return 32'($signed($urandom_range(0, 8191)) - 4096);
    endcase
  endfunction

  function automatic logic [6:0] pick_op();
    logic [6:0] ops [10];
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_CSR};
    if ($urandom_range(0, 19) == 0) return 7'($urandom);
    return ops[$urandom_range(0, 9)];
  endfunction

  initial begin
    logic [32:0] e2;

    // Reset state
    @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'h0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'h1);
    checkOutput("reset_out_insn", 64'(out_insn), 64'h0);
    @(posedge clk);
    #2;
    rst       = 1'b0;
    out_ready = 1'b1;
    idle(1);

    applyStimulus(OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    checkOutput("addi_insn", 64'(out_insn), 64'h0050_0093);
    checkOutput("addi_illegal", 64'(out_illegal), 64'h0);
    checkOutput("addi_count", 64'(encoded_count), 64'h1);

    applyStimulus(OP_REG, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    checkOutput("add_insn", 64'(out_insn), 64'h0020_81B3);
    applyStimulus(OP_REG, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    checkOutput("sub_insn", 64'(out_insn), 64'h4020_81B3);

    applyStimulus(OP_BR, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    checkOutput("beq_insn", 64'(out_insn), 64'h0020_8463);
    applyStimulus(OP_STORE, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4);
    checkOutput("sw_insn", 64'(out_insn), 64'h0020_A223);
    applyStimulus(OP_LUI, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    checkOutput("lui_insn", 64'(out_insn), 64'h1234_52B7);
    applyStimulus(OP_JAL, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
    checkOutput("jal_insn", 64'(out_insn), 64'h0010_00EF);
    applyStimulus(OP_IMM, 3'b101, 1'b1, 5'd4, 5'd6, 5'd0, 32'd7);
    checkOutput("srai_insn", 64'(out_insn), 64'h4073_5213);

    applyStimulus(OP_BR, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
    checkOutput("bad_beq_insn", 64'(out_insn), 64'h0);
    checkOutput("bad_beq_illegal", 64'(out_illegal), 64'h1);
    applyStimulus(OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096);
    checkOutput("bad_addi_insn", 64'(out_insn), 64'h0);
    checkOutput("bad_addi_illegal", 64'(out_illegal), 64'h1);
    checkOutput("illegal_count_2", 64'(illegal_count), 64'h2);
    idle(1);

    // Fill the FIFO with the consumer stalled
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(OP_IMM, 3'b000, 1'b0, 5'(k), 5'd0, 5'd0, 32'(k * 10));
    end
    checkOutput("full_in_ready", 64'(in_ready), 64'h0);
    in_imm   = 32'd50;
    in_rd    = 5'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("full_no_push", 64'(encoded_count), 64'(exp_enc));
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    e2 = ref_encode(OP_IMM, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd20);
    checkOutput("pop_head", 64'(out_insn), 64'(e2[31:0]));
    checkOutput("pop_in_ready", 64'(in_ready), 64'h1);
    @(posedge clk);
    #2;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(6);

    // Asynchronous reset with entries queued
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(OP_LOAD, 3'b010, 1'b0, 5'd7, 5'(k), 5'd0, 32'(k * 4));
    end
    rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", 64'(out_valid), 64'h0);
    checkOutput("arst_in_ready", 64'(in_ready), 64'h1);
    checkOutput("arst_encoded", 64'(encoded_count), 64'h0);
    checkOutput("arst_illegal", 64'(illegal_count), 64'h0);
    @(posedge clk);
    #2;
    rst       = 1'b0;
    out_ready = 1'b1;
    applyStimulus(OP_JALR, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC);
    checkOutput("post_rst_insn", 64'(out_insn), 64'hFFC1_00E7);
    idle(1);
    checkOutput("post_rst_alone", 64'(out_valid), 64'h0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      in_opcode = pick_op();
      in_funct3 = 3'($urandom);
      in_alt    = ($urandom_range(0, 3) == 0);
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_imm    = pick_imm();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #2;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(6);

    // Illegal counter saturation
    in_opcode = 7'h7F;
    in_valid  = 1'b1;
    repeat (260) begin
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    idle(6);
    checkOutput("illegal_sat", 64'(illegal_count), 64'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_insn_encoder.md
Name: rv32i_insn_encoder

Overview:
- Inverse of the control decoder. Takes decoded instruction fields (opcode, funct3, alt bit, register indices, full-width immediate) and produces the packed 32-bit RV32I instruction word.
- Used by the self-checking instruction injector / trace replayer to feed the pipeline's fetch path.
- Fields enter on a valid/ready handshake, are encoded and range-checked combinationally, then queued in an output FIFO drained on a second valid/ready handshake.
- Illegal field combinations are flagged and counted.

Parameters:
- DEPTH, 4, output FIFO entries (power of 2, ≥2)
- CNT_W, 16, width of the encoded-instruction counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_opcode  in  7  rv32i_opcode value
- in_funct3  in  3  funct3
- in_alt  in  1  funct7[5] (SUB/SRA/SRAI)
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  32  immediate as full signed byte value (U-type: full upper value; CSR: csr address)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_insn  out  32  encoded instruction at FIFO head
- out_illegal  out  1  head entry was illegal
- encoded_count  out  CNT_W  bundles accepted since reset, wraps
- illegal_count  out  8  illegal bundles accepted, saturates at 255

Behaviour:
- Reset (async, rst=1): FIFO empty; out_valid=0; out_insn=0; out_illegal=0; in_ready=1; both counters=0. If reset asserts mid-stream, all queued entries are discarded.
- Handshakes:
  - Accept when in_valid&&in_ready.
  - Pop when out_valid&&out_ready.
  - in_ready = (occupancy != DEPTH). It is registered-state only; there is no combinational path from out_ready.
  - Inputs must be stable only in the accept cycle.
- Latency: a bundle accepted in cycle N is visible at out_insn/out_valid in cycle N+1 when the FIFO was empty. Order is strictly FIFO.
- Simultaneous push and pop: occupancy is unchanged. When full, no push occurs, because in_ready=0. When empty, no pop occurs.
- Pointers are log2(DEPTH) bits and wrap; occupancy counter is log2(DEPTH)+1 bits.
- Encoding by opcode:
  - op_reg: R-type; funct7 = alt ? 0x20 : 0x00.
  - op_imm: I-type. For funct3 001/101, imm[11:5] = {1'b0, alt, 5'b0} and shamt = imm[4:0].
  - op_load / op_jalr / op_csr: I-type, imm[11:0].
  - op_store: S-type.
  - op_br: B-type, imm[12:1].
  - op_lui / op_auipc: U-type, imm[31:12].
  - op_jal: J-type, imm[20:1].
- Illegal conditions; entry is still enqueued with out_insn=0 and out_illegal=1:
  - Unknown opcode.
  - I/S imm outside [-2048, 2047].
  - Shift imm outside [0, 31].
  - B imm outside [-4096, 4094] or imm[0]=1.
  - J imm outside [-2^20, 2^20-2] or imm[0]=1.
  - U imm[11:0] != 0.
  - Load funct3 ∈ {011, 110, 111}.
  - Store funct3 > 010.
  - Branch funct3 ∈ {010, 011}.
  - op_jalr funct3 != 000.
  - alt=1 with op_reg funct3 ∉ {000, 101}.
  - alt=1 with op_imm funct3 != 101.
- Counters:
  - encoded_count increments on every accept.
  - illegal_count increments on an illegal accept and holds at 255.

Decomposition:
- rv32i_types already holds rv32i_opcode, branch_funct3_t, store/load funct3 enums. Add to it:
  - insn_format_t enum {fmt_r, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j}
  - constants FUNCT7_ALT=7'h20, NOP_INSN=32'h0000_0013
- One sub-module is natural: insn_pack (combinational field to word + illegal check), instanced ahead of the FIFO inside rv32i_insn_encoder.

Test Plan:
- ADDI x1,x0,5 (op_imm, f3=000, rd=1, imm=5) -> next cycle out_insn=0x00500093, out_illegal=0, encoded_count=1.
- ADD x3,x1,x2 then SUB (alt=1), back-to-back, out_ready=1 -> 0x002081B3 then 0x402081B3 on consecutive cycles.
- BEQ x1,x2,+8 -> 0x00208463; SW x2,4(x1) -> 0x0020A223; LUI x5,0x12345000 -> 0x123452B7; JAL x1,+2048 -> 0x001000EF.
- BEQ with imm=3 and ADDI with imm=4096 -> both out_insn=0, out_illegal=1, illegal_count=2.
- Hold out_ready=0 and push 5 bundles -> in_ready drops after the 4th accept. Then assert out_ready for one cycle with in_valid=1 -> one pop this cycle, no push until the next cycle, order preserved.
- Assert rst with 3 entries queued -> out_valid=0, in_ready=1, counters 0 immediately (async). First post-reset push emerges alone.
